// File: rtl/bg_frame_painter_pkg.sv
// Shared types and screen constants for the background frame painter.
// Used by bg_frame_painter and raster_counter.
package bg_frame_painter_pkg;

   localparam int unsigned SCREEN_W    = 160;
   localparam int unsigned SCREEN_H    = 120;
   localparam int unsigned COLOUR_BITS = 12;

   localparam logic [COLOUR_BITS-1:0] DEFAULT_KEY_COLOUR = 12'hF0F;

   typedef enum logic [1:0] {
      StIdle,
      StSweep,
      StFlush,
      StDone
   } state_e;

endpackage

// File: rtl/raster_counter.sv
// Column/row raster counter: cx runs 0..Width-1, then wraps and bumps cy.
// last_o flags the bottom-right pixel so the sweep knows when to stop.
module raster_counter
   import bg_frame_painter_pkg::*;
#(
   parameter int unsigned Width  = SCREEN_W,
   parameter int unsigned Height = SCREEN_H,
   parameter int unsigned CoordW = 8
) (
   input  logic              clk_i,
   input  logic              resetn_i,
   input  logic              clear_i,
   input  logic              advance_i,
   output logic [CoordW-1:0] cx_o,
   output logic [CoordW-1:0] cy_o,
   output logic              last_o
);

   logic [CoordW-1:0] cx_q, cx_d;
   logic [CoordW-1:0] cy_q, cy_d;
   logic              last_x, last_y;

   assign last_x = (cx_q == CoordW'(Width - 1));
   assign last_y = (cy_q == CoordW'(Height - 1));

   always_comb begin
      cx_d = cx_q;
      cy_d = cy_q;
      if (clear_i) begin
         cx_d = '0;
         cy_d = '0;
      end else if (advance_i) begin
         if (last_x) begin
            cx_d = '0;
            cy_d = last_y ? '0 : cy_q + CoordW'(1);
         end else begin
            cx_d = cx_q + CoordW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         cx_q <= '0;
         cy_q <= '0;
      end else begin
         cx_q <= cx_d;
         cy_q <= cy_d;
      end
   end

   assign cx_o   = cx_q;
   assign cy_o   = cy_q;
   assign last_o = last_x && last_y;

endmodule

// File: rtl/bg_frame_painter.sv
// Sweeps a full frame from a background ROM into the vga_adapter, one pixel per clock.
// Optional BG_TRANSPARENT_KEY_EN: suppress plot for pixels equal to KEY_COLOUR.
module bg_frame_painter
   import bg_frame_painter_pkg::*;
#(
   parameter int unsigned WIDTH    = SCREEN_W,
   parameter int unsigned HEIGHT   = SCREEN_H,
   parameter int unsigned COLOUR_W = COLOUR_BITS,
   parameter int unsigned ADDR_W   = 15
`ifdef BG_TRANSPARENT_KEY_EN
   ,
   parameter logic [COLOUR_W-1:0] KEY_COLOUR = DEFAULT_KEY_COLOUR
`endif
) (
   input  logic                clk_i,
   input  logic                resetn_i,
   input  logic                start_i,
   input  logic                abort_i,
   output logic [ADDR_W-1:0]   rom_addr_o,
   input  logic [COLOUR_W-1:0] rom_q_i,
   output logic [7:0]          x_o,
   output logic [7:0]          y_o,
   output logic [COLOUR_W-1:0] colour_o,
   output logic                plot_o,
   output logic                busy_o,
   output logic                done_o
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [7:0]        x_q, x_d;
   logic [7:0]        y_q, y_d;
   logic              plot_q, plot_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              sweeping;
   logic              cnt_clear;
   logic              cnt_advance;
   logic [7:0]        cx, cy;
   logic              cnt_last;

   raster_counter #(
      .Width  (WIDTH),
      .Height (HEIGHT),
      .CoordW (8)
   ) u_raster_counter (
      .clk_i     (clk_i),
      .resetn_i  (resetn_i),
      .clear_i   (cnt_clear),
      .advance_i (cnt_advance),
      .cx_o      (cx),
      .cy_o      (cy),
      .last_o    (cnt_last)
   );

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_i && !abort_i) state_d = StSweep;
         StSweep: begin
            if (abort_i) begin
               state_d = StIdle;
            end else if (cnt_last) begin
               state_d = StFlush;
            end
         end
         StFlush: state_d = abort_i ? StIdle : StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // The pixel addressed this cycle becomes the plotted pixel next cycle,
   // lining x/y/plot up with the ROM's one-cycle read latency.
   always_comb begin
      sweeping    = (state_q == StSweep) && !abort_i;
      cnt_clear   = !sweeping;
      cnt_advance = sweeping;
      rom_addr_d  = (sweeping && (state_d == StSweep)) ? rom_addr_q + ADDR_W'(1) : '0;
      plot_d      = sweeping;
      x_d         = sweeping ? cx : '0;
      y_d         = sweeping ? cy : '0;
      busy_d      = (state_d == StSweep) || (state_d == StFlush);
      done_d      = (state_d == StDone);
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         rom_addr_q <= '0;
         x_q        <= '0;
         y_q        <= '0;
         plot_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         rom_addr_q <= rom_addr_d;
         x_q        <= x_d;
         y_q        <= y_d;
         plot_q     <= plot_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign rom_addr_o = rom_addr_q;
   assign x_o        = x_q;
   assign y_o        = y_q;
   assign colour_o   = rom_q_i;
   assign busy_o     = busy_q;
   assign done_o     = done_q;

`ifdef BG_TRANSPARENT_KEY_EN
   assign plot_o = plot_q && (rom_q_i != KEY_COLOUR);
`else
   assign plot_o = plot_q;
`endif

endmodule

// File: doc/bg_frame_painter.md
# bg_frame_painter

Background frame painter for the whack-a-mole VGA path. On a start pulse it sweeps every pixel of the 160x120 screen in raster order, drives the address of a single-port background-image ROM (1-cycle registered read), and presents each returned colour with its x/y and a plot strobe directly to the `vga_adapter` `colour`/`x`/`y`/`plot` inputs. The top level selects which background ROM (start, game, game-end) feeds `rom_q`, and triggers one sweep per screen change.

## Interface
- `WIDTH`, 160, pixels per row
- `HEIGHT`, 120, rows per frame
- `COLOUR_W`, 12, colour bits (4 per channel)
- `ADDR_W`, 15, ROM address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT
- `KEY_COLOUR`, 12'hF0F, transparent colour (used only with the macro below)

Ports:
- `clk`  in  1  system clock (CLOCK_50)
- `resetn`  in  1  asynchronous, active-low reset
- `start`  in  1  request one full-frame sweep; sampled only in IDLE
- `abort`  in  1  synchronous cancel; returns to IDLE, no `done`
- `rom_addr`  out  ADDR_W  ROM read address
- `rom_q`  in  COLOUR_W  ROM data, valid one cycle after `rom_addr`
- `x`  out  8  pixel column to vga_adapter
- `y`  out  8  pixel row to vga_adapter
- `colour`  out  COLOUR_W  pixel colour to vga_adapter (= `rom_q`, combinational)
- `plot`  out  1  write strobe to vga_adapter
- `busy`  out  1  high while sweep/flush in progress
- `done`  out  1  one-cycle pulse after the last pixel is plotted

## Operation
- States: IDLE, SWEEP, FLUSH, DONE.
- IDLE: `busy`=0; `start`=1 -> SWEEP with column counter cx=0, row counter cy=0, `rom_addr`=0.
- SWEEP: each cycle issue `rom_addr`; advance cx; at cx=WIDTH-1 wrap cx to 0 and increment cy; `rom_addr` increments by 1 every cycle (no multiplier). When address WIDTH*HEIGHT-1 has been issued -> FLUSH.
- Pipeline: cx/cy and a valid bit are delayed one cycle into the x/y/plot registers so they align with `rom_q`.
- FLUSH: plots the final pixel (x=WIDTH-1, y=HEIGHT-1) -> DONE.
- DONE: `done`=1 for exactly one cycle -> IDLE.
- `start` outside IDLE is ignored (no queuing). `start` and `abort` together in IDLE: abort wins, stay IDLE.
- `abort` in SWEEP/FLUSH/DONE: next cycle IDLE, `plot`=0, `busy`=0, counters and `rom_addr` cleared, no `done`.
- `resetn` low at any time: immediately IDLE; `rom_addr`, `x`, `y`, `plot`, `busy`, `done` all 0.

## Timing
- `start` sampled high at edge of cycle 0 -> cycle 1: SWEEP, `busy`=1, `rom_addr`=0.
- Pixel n (n = y*WIDTH + x) addressed in cycle n+1, plotted (`plot`=1) in cycle n+2.
- Last pixel (n=19199) plotted in cycle 19201 (FLUSH); `done`=1 in cycle 19202, `busy`=0 from cycle 19202; IDLE in cycle 19203, earliest accepted next `start` there.
- Throughput: one pixel per clock; `plot` continuous from cycle 2 to 19201 (without the macro).
- `x`, `y`, `plot`, `busy`, `done`, `rom_addr` are registered; `colour` is combinational from `rom_q`.

## Configuration
- `BG_TRANSPARENT_KEY_EN` defined: `plot` is suppressed for any pixel whose `rom_q` equals `KEY_COLOUR`; counters, addressing and `done` timing unchanged (used for sprite overlay ROMs such as moles/hammer).
- Not defined: every pixel is plotted; `KEY_COLOUR` unused.

## Structure
- Shared package: state encoding (IDLE/SWEEP/FLUSH/DONE), screen constants SCREEN_W=160, SCREEN_H=120, COLOUR_W=12, default KEY_COLOUR.
- Single flat module; the x/y raster counter pair with wrap is a natural sub-module `raster_counter` (inputs clk, resetn, clear, advance; outputs cx, cy, last).

## Test plan
- Reset then `start` pulse with ROM content = address[11:0] -> 19200 plots, first (x=0,y=0,colour=0) in cycle 2, last (159,119,colour=12'hAFF) in cycle 19201, `done` in 19202.
- `start` held high throughout -> exactly one sweep per IDLE visit; second sweep `rom_addr`=0 in cycle 19204.
- `start` pulsed again mid-sweep (cycle 5000) -> ignored, total plot count 19200, single `done`.
- `abort` in cycle 100 -> cycle 101 `plot`=0, `busy`=0, no `done`; following `start` restarts at (0,0).
- `resetn` low in cycle 8000 -> all outputs 0 immediately; after release, idle until `start`.
- With `BG_TRANSPARENT_KEY_EN`, ROM = 12'hF0F at even addresses -> 9600 plots, only odd x, `done` still in cycle 19202.
